// File: rtl/fetch_stage_if.sv
// Fetch stage bus: instruction memory port, decode-stage control and IF/ID outputs.
interface fetch_stage_if;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        stall;
    logic [31:0] id_pc4;
    logic        br_taken;
    logic [15:0] br_imm;
    logic        jmp;
    logic [25:0] jmp_idx;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    // Fetch stage side
    modport master (
        output imem_pc,
        input  imem_instr,
        input  stall,
        input  id_pc4,
        input  br_taken,
        input  br_imm,
        input  jmp,
        input  jmp_idx,
        output ifid_instr,
        output ifid_pc4,
        output ifid_valid,
        output fetch_fault,
        output fetch_count
    );

    // Memory / decode / hazard side
    modport slave (
        input  imem_pc,
        output imem_instr,
        output stall,
        output id_pc4,
        output br_taken,
        output br_imm,
        output jmp,
        output jmp_idx,
        input  ifid_instr,
        input  ifid_pc4,
        input  ifid_valid,
        input  fetch_fault,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, registers the fetched word into IF/ID,
// handles stall, branch/jump redirects with wrong-path flush and sticky fetch faults.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 16384,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst_n,
    fetch_stage_if.master  bus
);

    localparam logic [31:0] LastAddr = 32'(IMEM_BYTES - 4);

    logic [31:0] pc_q;
    logic [31:0] ifid_instr_q;
    logic [31:0] ifid_pc4_q;
    logic        ifid_valid_q;
    logic        fault_q;
    logic [31:0] count_q;

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic        bad;

    // Next-PC candidates and fetch-address legality
    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        br_target  = bus.id_pc4 + {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};
        jmp_target = {bus.id_pc4[31:28], bus.jmp_idx, 2'b00};
        bad        = (pc_q[1:0] != 2'b00) || (pc_q > LastAddr);
    end

    // PC, IF/ID register and fetch counter, evaluated in strict priority order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_WORD;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            count_q      <= 32'd0;
        end else if (fault_q) begin
            // Sticky: only reset leaves this state
            ifid_instr_q <= NOP_WORD;
            ifid_valid_q <= 1'b0;
        end else if (bus.jmp || bus.br_taken) begin
            // Redirect overrides stall; the word fetched this cycle is wrong-path
            pc_q         <= bus.jmp ? jmp_target : br_target;
            ifid_instr_q <= NOP_WORD;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else if (bus.stall) begin
            // Hold everything, including a pending bubble
        end else if (bad) begin
            fault_q      <= 1'b1;
            ifid_instr_q <= NOP_WORD;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_plus4;
            ifid_instr_q <= bus.imem_instr;
            ifid_pc4_q   <= pc_plus4;
            ifid_valid_q <= 1'b1;
            count_q      <= count_q + 32'd1;
        end
    end

    // Outputs are straight from registers
    always_comb begin
        bus.imem_pc     = pc_q;
        bus.ifid_instr  = ifid_instr_q;
        bus.ifid_pc4    = ifid_pc4_q;
        bus.ifid_valid  = ifid_valid_q;
        bus.fetch_fault = fault_q;
        bus.fetch_count = count_q;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the 5-stage pipeline.
- Owns the program counter and drives it to the byte-addressed instruction memory. The memory has an asynchronous, combinational 32-bit big-endian read.
- Registers the returned word into the IF/ID pipeline register.
- Handles decode-stage stall, branch and jump redirects (with wrong-path flush), and out-of-range or misaligned fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 16384, instruction memory size in bytes. Last legal fetch address is IMEM_BYTES-4.
- NOP_WORD, 32'h0000_0000, word inserted into IF/ID on flush, fault or reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_pc  out  32  fetch address to instruction memory; equals the PC register
- imem_instr  in  32  instruction word returned combinationally for imem_pc
- stall  in  1  hazard unit: hold PC and IF/ID
- id_pc4  in  32  PC+4 of the instruction currently in decode; redirect base
- br_taken  in  1  decode: conditional branch resolved taken
- br_imm  in  16  branch word offset (signed)
- jmp  in  1  decode: unconditional jump
- jmp_idx  in  26  jump word index
- ifid_instr  out  32  registered instruction
- ifid_pc4  out  32  registered PC+4 of ifid_instr
- ifid_valid  out  1  ifid_instr is a real fetched instruction
- fetch_fault  out  1  sticky fault flag
- fetch_count  out  32  number of instructions accepted into IF/ID

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-stall):
  - pc=RESET_PC, ifid_instr=NOP_WORD, ifid_pc4=0.
  - ifid_valid=0, fetch_fault=0, fetch_count=0.
  - Takes effect immediately, without waiting for a clock edge.
- imem_pc = pc, combinational. Fetch latency: a word read at pc appears on ifid_* one edge later.
- Redirect targets:
  - Branch target = id_pc4 + ({{14{br_imm[15]}}, br_imm, 2'b00}), modulo 2^32.
  - Jump target = {id_pc4[31:28], jmp_idx, 2'b00}.
- "bad" = pc[1:0]!=0 OR pc > IMEM_BYTES-4.
- Each rising edge is evaluated in strict priority order:
  - 1. fetch_fault=1: pc holds, ifid_instr=NOP_WORD, ifid_valid=0, count holds. Only reset clears the fault.
  - 2. jmp=1: pc<=jump target. Flush: ifid_instr<=NOP_WORD, ifid_valid<=0, ifid_pc4<=0. Jump wins over a simultaneous br_taken.
  - 3. br_taken=1: pc<=branch target, with the same flush as a jump.
  - 4. stall=1: pc, ifid_* and count all hold. A redirect in the same cycle overrides stall (items 2-3 already apply).
  - 5. bad: fetch_fault<=1, ifid_valid<=0, ifid_instr<=NOP_WORD, pc holds.
  - 6. Normal fetch:
    - pc<=pc+4, wrapping modulo 2^32.
    - ifid_instr<=imem_instr, ifid_pc4<=pc+4, ifid_valid<=1.
    - fetch_count<=fetch_count+1, wrapping.
- A misaligned or out-of-range redirect target is loaded without complaint. The fault is raised on the first edge that would fetch from it (item 5).
- The flushed slot is the wrong-path word fetched in the same cycle as the redirect. Exactly one bubble per redirect.
- A stall directly after a redirect holds the bubble: ifid_valid stays 0.
- Implementation: single always block for the PC, IF/ID and counter. Combinational next-PC/target mux. No latches.

Test Plan:
- Reset then free-run with a memory model holding 0x4940_0000 at byte 0 and 0x4941_0004 at byte 4 → after edge 1: ifid_instr=0x4940_0000, ifid_pc4=4, valid=1. After edge 2: 0x4941_0004, pc4=8, imem_pc=8, fetch_count=2.
- stall=1 for 3 cycles at pc=8 → imem_pc stays 8, ifid_* unchanged, count unchanged. Release → normal fetch of byte 8 resumes.
- br_taken=1, id_pc4=404, br_imm=1 → next imem_pc=408, ifid_valid=0 for one cycle. br_imm=16'hFFFF with id_pc4=404 → imem_pc=400.
- jmp=1 and br_taken=1 together with stall=1, jmp_idx=2, id_pc4=0x0000_0220 → imem_pc=0x0000_0008 (jump wins over branch, redirect wins over stall), one bubble.
- Jump to idx 4096 (pc=16384) → next edge sets fetch_fault=1, pc stays 16384, ifid_valid=0 thereafter. Assert rst_n=0 mid-cycle → fault=0, imem_pc=0 immediately, without a clock edge.
- Branch to a misaligned target (id_pc4=2 → target 6) → fault on the following edge. fetch_count does not increment on flushed, stalled or faulted cycles.
